conv_featuremap_collector: RTL

- Synthesizable sink for the convolution stage output stream.
- Accepts one word per cycle qualified by the stage's donesignal and stores words row-major into an internal feature-map RAM (OUT_ROWS x OUT_COLS).
- Signals frame completion, then serves random-access reads to the next layer until released.
- Replaces the bench-side outmem/outputrow/outputcolomn collection logic with hardware.

---
 rtl/conv_featuremap_collector.sv | 116 +++++++++++
 1 files changed

// File: rtl/conv_featuremap_collector.sv
// Feature-map sink for the convolution output stream: collects one frame row-major
// into a local RAM, flags completion, then serves registered random-access reads.
module conv_featuremap_collector #(
  parameter int WORDLENGTH = 16,
  parameter int OUT_COLS   = 293,
  parameter int OUT_ROWS   = 166,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORDLENGTH-1:0] datain,
  input  logic                  donesignal,
  input  logic                  frame_release,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      rd_row,
  input  logic [CNT_W-1:0]      rd_col,
  output logic [WORDLENGTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      wr_row,
  output logic [CNT_W-1:0]      wr_col,
  output logic                  frame_done,
  output logic                  ready,
  output logic                  overflow
);

  localparam int DEPTH = OUT_ROWS * OUT_COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_ROWS - 1);
  localparam logic [CNT_W-1:0] NCOLS    = CNT_W'(OUT_COLS);
  localparam logic [CNT_W-1:0] NROWS    = CNT_W'(OUT_ROWS);

  typedef enum logic {COLLECT, READY} state_t;

  state_t                state, state_next;
  logic [WORDLENGTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      row_next, col_next;
  logic                  we, last_write, overflow_next;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic                  rd_in_range, rd_fire;

  assign wr_addr     = AW'(wr_row) * AW'(OUT_COLS) + AW'(wr_col);
  assign rd_addr     = AW'(rd_row) * AW'(OUT_COLS) + AW'(rd_col);
  assign rd_in_range = (rd_row < NROWS) && (rd_col < NCOLS);
  assign rd_fire     = (state == READY) && rd_en;
  assign ready       = (state == READY);

  always_comb begin
    state_next    = state;
    row_next      = wr_row;
    col_next      = wr_col;
    we            = 1'b0;
    last_write    = 1'b0;
    overflow_next = overflow;
    case (state)
      COLLECT: we = donesignal;
      READY: begin
        // Release takes the colliding sample as the first word of the next frame.
        if (frame_release) begin
          state_next    = COLLECT;
          overflow_next = 1'b0;
          we            = donesignal;
        end else if (donesignal) begin
          overflow_next = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase

    if (we) begin
      if (wr_col == LAST_COL) begin
        col_next = '0;
        if (wr_row == LAST_ROW) begin
          row_next   = '0;
          last_write = 1'b1;
          state_next = READY;
        end else begin
          row_next = wr_row + CNT_W'(1);
        end
      end else begin
        col_next = wr_col + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      wr_row     <= '0;
      wr_col     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_next;
      wr_row     <= row_next;
      wr_col     <= col_next;
      frame_done <= last_write;
      overflow   <= overflow_next;
      rd_valid   <= rd_fire;
      if (rd_fire) begin
        rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

  // Storage has no reset so it maps onto block RAM; the read above sees pre-write data.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wr_addr] <= datain;
    end
  end

endmodule
